// File: rtl/msrv32_dmem_bus_if_pkg.sv
// Shared msrv32 definitions for the data-memory AHB-Lite master:
// FSM state encoding, HTRANS codes, access size codes and the alignment rule.
package msrv32_dmem_bus_if_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'b00,
        DMEM_ADDR = 2'b01,
        DMEM_DATA = 2'b10
    } dmem_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    // Byte accesses never fault; the illegal size code always does.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lsb);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_HALF:    mis = addr_lsb[0];
            SIZE_WORD:    mis = (addr_lsb != 2'b00);
            SIZE_ILLEGAL: mis = 1'b1;
            default:      mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/msrv32_dmem_bus_if.sv
// Data-memory bus interface: turns one pipeline load/store request into a single
// AHB-Lite NONSEQ transfer, with alignment checking and a wait-state timeout.
module msrv32_dmem_bus_if #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        mem_req_in,
    input  logic        mem_wr_req_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_wdata_in,
    input  logic [1:0]  mem_size_in,
    input  logic        hready_in,
    input  logic        hresp_in,
    input  logic [31:0] hrdata_in,
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic        hwrite_out,
    output logic [2:0]  hsize_out,
    output logic [31:0] hwdata_out,
    output logic [31:0] ms_riscv32_mp_dmdata_out,
    output logic        ahb_resp_out,
    output logic        done_out,
    output logic        stall_out,
    output logic        misaligned_out
);
    import msrv32_dmem_bus_if_pkg::*;

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    dmem_state_e       state_q;
    logic [31:0]       haddr_q;
    logic [1:0]        htrans_q;
    logic              hwrite_q;
    logic [2:0]        hsize_q;
    logic [31:0]       hwdata_q;
    logic [31:0]       dmdata_q;
    logic              resp_q;
    logic              done_q;
    logic              misaligned_q;
    logic [WAIT_W-1:0] waitCnt_q;
    logic              reqMisaligned;

    assign reqMisaligned = is_misaligned(mem_size_in, mem_addr_in[1:0]);

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q      <= DMEM_IDLE;
            haddr_q      <= '0;
            htrans_q     <= HTRANS_IDLE;
            hwrite_q     <= 1'b0;
            hsize_q      <= '0;
            hwdata_q     <= '0;
            dmdata_q     <= '0;
            resp_q       <= 1'b0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            waitCnt_q    <= '0;
        end else begin
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            case (state_q)
                // The pipeline keeps mem_req_in high during the done cycle, so done_q blocks a re-issue.
                DMEM_IDLE: begin
                    if (mem_req_in && !done_q) begin
                        if (reqMisaligned) begin
                            done_q       <= 1'b1;
                            misaligned_q <= 1'b1;
                            resp_q       <= 1'b1;
                        end else begin
                            haddr_q   <= mem_addr_in;
                            hwrite_q  <= mem_wr_req_in;
                            hsize_q   <= {1'b0, mem_size_in};
                            htrans_q  <= HTRANS_NONSEQ;
                            waitCnt_q <= '0;
                            state_q   <= DMEM_ADDR;
                        end
                    end
                end
                DMEM_ADDR, DMEM_DATA: begin
                    if (!hready_in) begin
                        if (waitCnt_q == WAIT_LAST) begin
                            htrans_q  <= HTRANS_IDLE;
                            hwrite_q  <= 1'b0;
                            resp_q    <= 1'b1;
                            done_q    <= 1'b1;
                            waitCnt_q <= '0;
                            state_q   <= DMEM_IDLE;
                        end else begin
                            waitCnt_q <= waitCnt_q + 1'b1;
                        end
                    end else if (state_q == DMEM_ADDR) begin
                        htrans_q  <= HTRANS_IDLE;
                        hwdata_q  <= mem_wdata_in;
                        waitCnt_q <= '0;
                        state_q   <= DMEM_DATA;
                    end else begin
                        if (!hresp_in && !hwrite_q) begin
                            dmdata_q <= hrdata_in;
                        end
                        resp_q    <= hresp_in;
                        hwrite_q  <= 1'b0;
                        done_q    <= 1'b1;
                        waitCnt_q <= '0;
                        state_q   <= DMEM_IDLE;
                    end
                end
                default: begin
                    state_q <= DMEM_IDLE;
                end
            endcase
        end
    end

    assign haddr_out                = haddr_q;
    assign htrans_out               = htrans_q;
    assign hwrite_out               = hwrite_q;
    assign hsize_out                = hsize_q;
    assign hwdata_out               = hwdata_q;
    assign ms_riscv32_mp_dmdata_out = dmdata_q;
    assign ahb_resp_out             = resp_q;
    assign done_out                 = done_q;
    assign misaligned_out           = misaligned_q;
    assign stall_out                = (state_q != DMEM_IDLE) || (mem_req_in && !done_q);

endmodule

// File: doc/msrv32_dmem_bus_if.md
MSRV32_DMEM_BUS_IF -- requirements
Module: msrv32_dmem_bus_if

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of consecutive hready_in-low cycles in one transfer after which the transfer is aborted.
REQ-002 SHALL have port ms_riscv32_mp_clk_in  in  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port ms_riscv32_mp_rst_in  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port mem_req_in  in  1  access request from the pipeline, held high until done_out is seen.
REQ-005 SHALL have port mem_wr_req_in  in  1  access type: 1 = store, 0 = load.
REQ-006 SHALL have port mem_addr_in  in  32  byte address.
REQ-007 SHALL have port mem_wdata_in  in  32  store data, already lane-aligned.
REQ-008 SHALL have port mem_size_in  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 SHALL have ports hready_in (in, 1), hresp_in (in, 1; 1 = ERROR) and hrdata_in (in, 32).
REQ-010 SHALL have ports haddr_out (out, 32), htrans_out (out, 2; 00 = IDLE, 10 = NONSEQ), hwrite_out (out, 1), hsize_out (out, 3) and hwdata_out (out, 32).
REQ-011 SHALL have port ms_riscv32_mp_dmdata_out  out  32  captured read word, fed to the load unit.
REQ-012 SHALL have port ahb_resp_out  out  1  completion status to the load unit: 0 = OK, 1 = error.
REQ-013 SHALL have ports done_out (out, 1; one-cycle completion pulse), stall_out (out, 1; access pending) and misaligned_out (out, 1; one-cycle pulse).

Function
REQ-014 SHALL implement an FSM with the states IDLE, ADDR and DATA.
REQ-015 IDLE: when mem_req_in=1 and done_out=0 and the request is aligned, the FSM SHALL register haddr, hwrite and hsize={1'b0, mem_size_in}, drive htrans=NONSEQ, and go to ADDR.
REQ-016 ADDR: the FSM SHALL hold the address-phase outputs while hready_in=0; on hready_in=1 it SHALL drive htrans=IDLE, register hwdata_out from mem_wdata_in, and go to DATA.
REQ-017 DATA: on hready_in=1 with hresp_in=0 the FSM SHALL capture hrdata_in into ms_riscv32_mp_dmdata_out (loads only; stores leave it unchanged), set ahb_resp_out=0, and return to IDLE.
REQ-018 DATA: on hready_in=1 with hresp_in=1 the FSM SHALL set ahb_resp_out=1, leave ms_riscv32_mp_dmdata_out unchanged, and return to IDLE.
REQ-019 done_out SHALL pulse high for exactly one cycle, in the cycle after leaving DATA.
REQ-020 With zero wait states, done_out SHALL assert 3 cycles after the cycle in which mem_req_in is first sampled in IDLE.
REQ-021 Misalignment SHALL be defined as: half with addr[0]=1, word with addr[1:0]!=00, or mem_size_in=11.
REQ-022 A misaligned request SHALL start no bus transfer and SHALL produce, in the next cycle, a one-cycle pulse of misaligned_out and done_out together with ahb_resp_out=1.
REQ-023 A wait counter SHALL count consecutive hready_in=0 cycles in ADDR or DATA and clear on hready_in=1.
REQ-024 When the wait counter reaches TIMEOUT_CYCLES, the FSM SHALL drive htrans=IDLE, set ahb_resp_out=1, go to IDLE, and pulse done_out in the next cycle.
REQ-025 stall_out SHALL be high in ADDR and DATA, and in IDLE whenever mem_req_in=1 and done_out=0.
REQ-026 Changes on the request inputs outside IDLE SHALL be ignored; requests SHALL be sampled only in IDLE.
REQ-027 In IDLE, htrans_out SHALL be IDLE and hwrite_out SHALL be 0.

Reset
REQ-028 While ms_riscv32_mp_rst_in=1 at a clock edge, the next state SHALL be IDLE and: haddr_out=0, htrans_out=00, hwrite_out=0, hsize_out=000, hwdata_out=0, ms_riscv32_mp_dmdata_out=0, ahb_resp_out=0, done_out=0, stall_out=0, misaligned_out=0, wait counter=0.
REQ-029 A reset during ADDR or DATA SHALL abandon the transfer, with no done_out pulse after reset.
REQ-030 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-031 The FSM state encoding, the HTRANS codes (IDLE, NONSEQ) and the size codes SHALL reside in the shared msrv32 package.
REQ-032 The block SHALL be a single module with no sub-modules; the wait counter is inline with width $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-033 Load word, addr 0x100, hready=1 throughout, hrdata=0xAABBCCDD -> htrans=NONSEQ at cycle 1, done_out at cycle 3, dmdata=0xAABBCCDD, ahb_resp_out=0.
REQ-034 Store half, addr 0x102, wdata=0x12340000, 2 wait states in DATA -> hwrite=1, hsize=001, hwdata=0x12340000, done_out at cycle 5.
REQ-035 Load word, addr 0x101 -> no NONSEQ issued; misaligned_out, done_out and ahb_resp_out=1 at cycle 1.
REQ-036 Load with hresp=1 and hready=1 in DATA -> ahb_resp_out=1, dmdata keeps its previous value.
REQ-037 hready held 0 in ADDR for 16 cycles -> abort, done_out with ahb_resp_out=1, htrans=IDLE.
REQ-038 Reset asserted in DATA -> next cycle all outputs are at reset values and no done_out follows.
